seed_out_collector: RTL
=======================

# seed_out_collector

Parametrised output stage of the SEED datapath. Replaces the single-register final-round capture with a small output buffer. Captures the L/R halves when the round counter reports the last round and queues each block in a FIFO. Blocks are then presented on a valid/ready interface, so the downstream consumer may stall without losing ciphertext.

## Interface
- BLOCK_W, 128, ciphertext width; even, ≥ 16.
- ROUND_W, 4, round index width.
- LAST_ROUND, 15, round index that marks a finished block.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  datapath enable pulse (one cycle in two); qualifies capture only.
- round_valid  in  1  round result on L/R is valid this enable cycle.
- Rounds  in  ROUND_W  index of the round whose result is on L/R.
- L  in  BLOCK_W/2  left half from the last round.
- R  in  BLOCK_W/2  right half from the last round.
- flush  in  1  synchronous clear of FIFO contents and overflow flag.
- out_ready  in  1  consumer accepts the head block.
- ciphertext  out  BLOCK_W  head-of-FIFO block; all zero when empty.
- out_valid  out  1  FIFO non-empty.
- level  out  $clog2(DEPTH)+1  entries currently held.
- overflow  out  1  sticky; a finished block was dropped because the FIFO was full.
- blocks_done  out  CNT_W  count of blocks accepted into the FIFO; wraps modulo 2^CNT_W.

## Operation
- Capture event: clk_en && round_valid && Rounds == LAST_ROUND on a rising clk edge.
- Pop event: out_valid && out_ready on any rising clk edge. Not gated by clk_en.
- On capture, if not full, or full with a pop in the same cycle:
  - write {L,R} at the write pointer;
  - advance the write pointer;
  - increment blocks_done.
- On capture while full without a pop:
  - block dropped;
  - overflow set;
  - pointers and blocks_done unchanged.
- Simultaneous capture and pop: level unchanged; head advances; new block written at the tail.
- Pointers are ($clog2(DEPTH)+1) bits with the wrap bit.
  - full = MSBs differ, lower bits equal.
  - empty = pointers equal.
- flush has priority over capture and pop in its cycle:
  - pointers zeroed, overflow cleared;
  - blocks_done NOT cleared;
  - a capture in the flush cycle is discarded.
- Control state, derived from level:
  - EMPTY (level 0), PARTIAL, FULL (level DEPTH).
  - EMPTY→PARTIAL on push; PARTIAL→FULL on push without pop.
  - FULL→PARTIAL on pop; PARTIAL→EMPTY on last pop.
  - Any state→EMPTY on flush.
- Round indices other than LAST_ROUND are ignored. No per-block state is kept between rounds.

## Timing
- Reset (reset_n low, async assert, sync release inside the block):
  - ciphertext = 0, out_valid = 0, level = 0, overflow = 0, blocks_done = 0;
  - FIFO storage need not be cleared.
- Latency: a capture at edge N gives out_valid = 1 and ciphertext = the block after edge N.
- Throughput: one pop per clk; one capture per clk_en pulse.
- ciphertext and out_valid are stable while out_valid && !out_ready (AXI-style hold).
- overflow rises the cycle after the dropping edge. It stays high until flush or reset.
- reset_n asserted mid-operation discards all queued blocks immediately; outputs go to reset values asynchronously.

## Configuration
- Macro SEED_OUT_FINAL_SWAP_EN.
  - Defined: stored block is {R,L}. This is the undo of the final-round half swap, so ciphertext matches the SEED reference vector ordering.
  - Undefined: stored block is {L,R}, the legacy ordering.
- No other behaviour changes.

## Test plan
- Reset then a single block: L=64'h0123456789ABCDEF, R=64'hFEDCBA9876543210 at Rounds=15 with clk_en, out_ready=1.
  - out_valid pulses for exactly one cycle, one edge after capture.
  - ciphertext = {L,R}, or {R,L} with the macro defined.
  - blocks_done = 1.
- Non-final rounds: Rounds=0..14 with round_valid on every clk_en, out_ready=1 → out_valid stays 0, blocks_done stays 0.
- Backpressure: out_ready=0, five blocks A..E at DEPTH=4.
  - level reaches 4; E dropped; overflow = 1; blocks_done = 4.
  - Then out_ready=1: outputs A,B,C,D in order, one per clk; ending level = 0, overflow still 1.
- Simultaneous push/pop at full: level 4, capture with out_ready=1 in the same cycle → level stays 4, no overflow, head advances to the next block.
- flush at level 3 with a coincident capture → next cycle level = 0, out_valid = 0, overflow = 0; blocks_done unchanged.
- Mid-operation reset: reset_n low for 3 cycles at level 2, asynchronous to the edge → all outputs zero immediately; after release, the next block is captured normally.

Source files
------------

// File: rtl/seed_out_collector_if.sv
// Output stream of the SEED collector: head-of-FIFO block with valid/ready handshake.
interface seed_out_collector_if #(
  parameter int unsigned BLOCK_W = 128
);
  logic [BLOCK_W-1:0] ciphertext;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output ciphertext,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  ciphertext,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/seed_out_collector.sv
// SEED output stage: captures final-round L/R halves into a FIFO and streams them out.
// Define SEED_OUT_FINAL_SWAP_EN to store {R,L} (reference ordering) instead of legacy {L,R}.
module seed_out_collector #(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned ROUND_W    = 4,
  parameter int unsigned LAST_ROUND = 15,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_en,
  input  logic                     round_valid,
  input  logic [ROUND_W-1:0]       Rounds,
  input  logic [BLOCK_W/2-1:0]     L,
  input  logic [BLOCK_W/2-1:0]     R,
  input  logic                     flush,
  seed_out_collector_if.master     out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         blocks_done
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [BLOCK_W-1:0] blk_in;
  logic [PTR_W-1:0]   fill;
  logic               capture, full, empty, pop, push, drop;

  // Assert asynchronously, release two edges later so all state leaves reset together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

`ifdef SEED_OUT_FINAL_SWAP_EN
  assign blk_in = {R, L};
`else
  assign blk_in = {L, R};
`endif

  assign capture = clk_en && round_valid && (Rounds == ROUND_W'(LAST_ROUND));
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && out_if.out_ready;
  assign push    = !flush && capture && (!full || pop);
  assign drop    = !flush && capture && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty:   if (push) state_d = StPartial;
        StPartial: begin
          if (push && !pop && fill == PTR_W'(DEPTH - 1))  state_d = StFull;
          else if (pop && !push && fill == PTR_W'(1))     state_d = StEmpty;
        end
        StFull:    if (pop && !push) state_d = StPartial;
        default:   state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= StEmpty;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= blk_in;
  end

  assign out_if.out_valid  = (state_q != StEmpty);
  assign out_if.ciphertext = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level             = fill;
  assign overflow          = overflow_q;
  assign blocks_done       = cnt_q;

endmodule
